// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared ALU op codes, instruction field enums and datapath constants.
package mips_cpu_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] HILO_RST = 32'h0;

    typedef enum logic [3:0] {
        op_and   = 4'b0000,
        op_or    = 4'b0001,
        op_xor   = 4'b0010,
        op_nor   = 4'b0011,
        op_add   = 4'b0100,
        op_sub   = 4'b0101,
        op_slt   = 4'b0110,
        op_sltu  = 4'b0111,
        op_sll   = 4'b1000,
        op_srl   = 4'b1001,
        op_sra   = 4'b1010,
        op_mult  = 4'b1011,
        op_multu = 4'b1100,
        op_div   = 4'b1101,
        op_divu  = 4'b1110,
        op_none  = 4'b1111
    } aluOp_t;

    typedef enum logic [5:0] {
        opc_rtype  = 6'h00,
        opc_regimm = 6'h01,
        opc_j      = 6'h02,
        opc_jal    = 6'h03,
        opc_beq    = 6'h04,
        opc_bne    = 6'h05,
        opc_blez   = 6'h06,
        opc_bgtz   = 6'h07,
        opc_addiu  = 6'h09,
        opc_slti   = 6'h0a,
        opc_sltiu  = 6'h0b,
        opc_andi   = 6'h0c,
        opc_ori    = 6'h0d,
        opc_xori   = 6'h0e,
        opc_lui    = 6'h0f,
        opc_lw     = 6'h23,
        opc_sw     = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        fn_sll   = 6'h00,
        fn_srl   = 6'h02,
        fn_sra   = 6'h03,
        fn_sllv  = 6'h04,
        fn_srlv  = 6'h06,
        fn_srav  = 6'h07,
        fn_jr    = 6'h08,
        fn_jalr  = 6'h09,
        fn_mfhi  = 6'h10,
        fn_mthi  = 6'h11,
        fn_mflo  = 6'h12,
        fn_mtlo  = 6'h13,
        fn_mult  = 6'h18,
        fn_multu = 6'h19,
        fn_div   = 6'h1a,
        fn_divu  = 6'h1b,
        fn_addu  = 6'h21,
        fn_subu  = 6'h23,
        fn_and   = 6'h24,
        fn_or    = 6'h25,
        fn_xor   = 6'h26,
        fn_nor   = 6'h27,
        fn_slt   = 6'h2a,
        fn_sltu  = 6'h2b
    } funct_t;
endpackage

// File: rtl/mips_cpu_alu_hilo.sv
// mips_cpu_alu_hilo: HI/LO register pair with MTHI/MTLO loads, multiply and optional divide.
// Divide datapath exists only when MIPS_CPU_ALU_DIV_EN is defined.
module mips_cpu_alu_hilo
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  aluOp_t            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              en,
    input  logic [1:0]        hilo_wr,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    logic [2*DATA_W-1:0] prodS, prodU, divRes;
    logic [DATA_W-1:0] hiNext, loNext;
    logic divOk;

    // Sign-extending to 64 bits lets one unsigned multiply yield the signed product.
    assign prodS = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    assign prodU = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

`ifdef MIPS_CPU_ALU_DIV_EN
    logic isSigned, negA, negQ;
    logic [DATA_W-1:0] aMag, bMag, qMag, rMag;
    assign isSigned = op == op_div;
    assign negA = isSigned && a[DATA_W-1];
    assign negQ = isSigned && (a[DATA_W-1] ^ b[DATA_W-1]);
    assign aMag = negA ? -a : a;
    assign bMag = (isSigned && b[DATA_W-1]) ? -b : b;
    assign qMag = aMag / bMag;
    assign rMag = aMag % bMag;
    assign divOk = (op == op_div || op == op_divu) && b != '0;
    assign divRes = {negA ? -rMag : rMag, negQ ? -qMag : qMag};
`else
    assign divOk = 1'b0;
    assign divRes = '0;
`endif

    always_comb begin
        hiNext = hi;
        loNext = lo;
        if (en && hilo_wr != 2'b00) begin
            hiNext = hilo_wr[1] ? a : hi;
            loNext = hilo_wr[0] ? a : lo;
        end else if (en && op == op_mult) begin
            {hiNext, loNext} = prodS;
        end else if (en && op == op_multu) begin
            {hiNext, loNext} = prodU;
        end else if (en && divOk) begin
            {hiNext, loNext} = divRes;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= HILO_RST;
            lo <= HILO_RST;
        end else begin
            hi <= hiNext;
            lo <= loNext;
        end
    end
endmodule

// File: rtl/mips_cpu_alu_unit.sv
// mips_cpu_alu_unit: execute-stage ALU with combinational r/zero and a HI/LO register pair.
// Define MIPS_CPU_ALU_DIV_EN to enable the single-cycle DIV/DIVU datapath.
module mips_cpu_alu_unit
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        control,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        sa,
    input  logic              en,
    input  logic [1:0]        hilo_wr,
    output logic [DATA_W-1:0] r,
    output logic              zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    aluOp_t op;
    assign op = aluOp_t'(control);

    always_comb begin
        r = '0;
        case (op)
            op_and:  r = a & b;
            op_or:   r = a | b;
            op_xor:  r = a ^ b;
            op_nor:  r = ~(a | b);
            op_add:  r = a + b;
            op_sub:  r = a - b;
            op_slt:  r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            op_sltu: r = {{(DATA_W-1){1'b0}}, a < b};
            op_sll:  r = b << sa;
            op_srl:  r = b >> sa;
            op_sra:  r = $signed(b) >>> sa;
            default: r = '0;
        endcase
    end

    assign zero = ~|r;

    mips_cpu_alu_hilo hiloUnit (
        .clk(clk),
        .reset(reset),
        .op(op),
        .a(a),
        .b(b),
        .en(en),
        .hilo_wr(hilo_wr),
        .hi(hi),
        .lo(lo)
    );
endmodule

// File: tb/tb_mips_cpu_alu_unit.sv
// tb_mips_cpu_alu_unit: directed and random checks of mips_cpu_alu_unit against an arithmetic model.
module tb_mips_cpu_alu_unit;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] control;
    logic [31:0] a, b;
    logic [4:0] sa;
    logic en;
    logic [1:0] hilo_wr;
    logic [31:0] r, hi, lo;
    logic zero;

    int total = 0;
    int passCnt = 0;
    int failCnt = 0;
    string stepName = "init";
    logic [31:0] mHi, mLo;

    mips_cpu_alu_unit dut (
        .clk(clk), .reset(reset), .control(control), .a(a), .b(b), .sa(sa),
        .en(en), .hilo_wr(hilo_wr), .r(r), .zero(zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refR(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        case (c)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x ^ y;
            4'd3:    return ~(x | y);
            4'd4:    return x + y;
            4'd5:    return x - y;
            4'd6:    return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd7:    return (x < y) ? 32'd1 : 32'd0;
            4'd8:    return y << s;
            4'd9:    return y >> s;
            4'd10:   return int'(y) >>> s;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s.%s observed=%h expected=%h", stepName, tag, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s, input logic e, input logic [1:0] w);
        logic [31:0] er;
        longint p;
        reset = rs; control = c; a = x; b = y; sa = s; en = e; hilo_wr = w;
        #2;
        er = refR(c, x, y, s);
        check("r", r, er);
        check("zero", {31'b0, zero}, {31'b0, er == 32'h0});
        if (rs) begin
            mHi = 32'h0;
            mLo = 32'h0;
        end else if (e && w != 2'b00) begin
            if (w[1]) mHi = x;
            if (w[0]) mLo = x;
        end else if (e && c == 4'd11) begin
            p = longint'(int'(x)) * longint'(int'(y));
            mHi = p[63:32];
            mLo = p[31:0];
        end else if (e && c == 4'd12) begin
            p = longint'({32'b0, x}) * longint'({32'b0, y});
            mHi = p[63:32];
            mLo = p[31:0];
        end
`ifdef MIPS_CPU_ALU_DIV_EN
        else if (e && c == 4'd13 && y != 32'h0) begin
            p = longint'(int'(x)) / longint'(int'(y));
            mLo = p[31:0];
            p = longint'(int'(x)) % longint'(int'(y));
            mHi = p[31:0];
        end else if (e && c == 4'd14 && y != 32'h0) begin
            mLo = x / y;
            mHi = x % y;
        end
`endif
        @(posedge clk);
        #1;
        check("hi", hi, mHi);
        check("lo", lo, mLo);
    endtask

    initial begin
        reset = 1'b1; control = 4'hf; a = '0; b = '0; sa = '0; en = 1'b0; hilo_wr = 2'b00;
        mHi = 32'h0; mLo = 32'h0;
        stepName = "reset";   step(1, 4'd15, 32'h0, 32'h0, 5'd0, 0, 2'b00);
        check("hi_rst", hi, 32'h0);
        stepName = "add";     step(0, 4'd4, 32'hFFFFFFFF, 32'h1, 5'd0, 0, 2'b00);
        check("add_r", r, 32'h0);
        check("add_zero", {31'b0, zero}, 32'h1);
        stepName = "sub";     step(0, 4'd5, 32'h5, 32'h7, 5'd0, 0, 2'b00);
        check("sub_r", r, 32'hFFFFFFFE);
        stepName = "slt";     step(0, 4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 0, 2'b00);
        check("slt_r", r, 32'h1);
        stepName = "sltu";    step(0, 4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 0, 2'b00);
        check("sltu_r", r, 32'h0);
        stepName = "nor";     step(0, 4'd3, 32'h0, 32'h0, 5'd0, 0, 2'b00);
        check("nor_r", r, 32'hFFFFFFFF);
        stepName = "sra";     step(0, 4'd10, 32'h0, 32'h80000000, 5'd4, 0, 2'b00);
        check("sra_r", r, 32'hF8000000);
        stepName = "srl";     step(0, 4'd9, 32'h0, 32'h80000000, 5'd4, 0, 2'b00);
        check("srl_r", r, 32'h08000000);
        stepName = "sll";     step(0, 4'd8, 32'h0, 32'h1, 5'd31, 0, 2'b00);
        check("sll_r", r, 32'h80000000);
        stepName = "sll0";    step(0, 4'd8, 32'h0, 32'hA5A5_0F0F, 5'd0, 0, 2'b00);
        check("sll0_r", r, 32'hA5A5_0F0F);
        stepName = "mult";    step(0, 4'd11, 32'hFFFFFFFE, 32'h3, 5'd0, 1, 2'b00);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        stepName = "multu";   step(0, 4'd12, 32'hFFFFFFFE, 32'h3, 5'd0, 1, 2'b00);
        check("multu_hi", hi, 32'h2);
        check("multu_lo", lo, 32'hFFFFFFFA);
        stepName = "en0";     step(0, 4'd11, 32'h7, 32'h9, 5'd0, 0, 2'b11);
        check("en0_hi", hi, 32'h2);
        stepName = "mthi";    step(0, 4'd11, 32'h12345678, 32'h3, 5'd0, 1, 2'b10);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'hFFFFFFFA);
        stepName = "mtlo";    step(0, 4'd0, 32'hCAFEF00D, 32'h3, 5'd0, 1, 2'b01);
        check("mtlo_lo", lo, 32'hCAFEF00D);
        stepName = "div";     step(0, 4'd13, 32'hFFFFFFF9, 32'h2, 5'd0, 1, 2'b00);
        check("div_r", r, 32'h0);
`ifdef MIPS_CPU_ALU_DIV_EN
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
`else
        check("div_lo", lo, 32'hCAFEF00D);
        check("div_hi", hi, 32'h12345678);
`endif
        stepName = "divu0";   step(0, 4'd14, 32'h1234, 32'h0, 5'd0, 1, 2'b00);
        stepName = "divovf";  step(0, 4'd13, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1, 2'b00);
`ifdef MIPS_CPU_ALU_DIV_EN
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h0);
`endif
        stepName = "rstprio"; step(1, 4'd11, 32'hFFFFFFFE, 32'h3, 5'd0, 1, 2'b11);
        check("rstprio_hi", hi, 32'h0);
        check("rstprio_lo", lo, 32'h0);
        stepName = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0,
                 4'($urandom),
                 $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                 5'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
        end
        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end
endmodule
